qarma64_tweak_sched: RTL and testbench
======================================

Name: qarma64_tweak_sched

Overview:
- Iterative QARMA-64 tweak schedule engine.
- Accepts one 64-bit tweak and streams every round tweak over a valid/ready interface.
- Forward half: applies the tweak update (cell shuffle h, then LFSR omega) ROUNDS times.
- Backward half: applies the exact inverse update (inverse omega, then inverse h) to walk back to the original tweak.
- Feeds the round-key/tweakey mixer of the iterative QARMA-64 datapath and self-checks that the backward walk returns to the input.

Parameters:
- ROUNDS, 7, number of forward updates (and of backward updates); legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  tweak load request
- in_ready  output  1  high in IDLE only
- in_tk  input  64  initial tweak T0; cell 0 = bits[63:60] … cell 15 = bits[3:0]
- abort  input  1  synchronous abort, returns to IDLE
- out_valid  output  1  round tweak available
- out_ready  input  1  consumer accepts out_tk
- out_tk  output  64  current round tweak
- out_idx  output  4  round index of out_tk (0..ROUNDS)
- out_dir  output  1  0 = forward half, 1 = backward half
- out_last  output  1  final beat of the sequence
- chk_err  output  1  sticky mismatch flag; cleared on the next accepted load

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE; out_valid=0; out_tk=0; out_idx=0; out_dir=0; out_last=0; chk_err=0.
  - in_ready=1 once rst is released.
- Forward update U(x):
  - y = h(x): y.cell[i] = x.cell[h[i]], h = [6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11].
  - Then omega on cells {0,1,3,4,8,11,13}: (b3,b2,b1,b0) -> (b0^b1, b3, b2, b1), b3 = MSB of cell. Other cells unchanged.
- Backward update V(x) = U^-1(x):
  - Inverse omega on the same cells: (b3,b2,b1,b0) -> (b2, b1, b0, b3^b0).
  - Then inverse h: y.cell[h[i]] = x.cell[i].
- Output sequence, 2*ROUNDS+1 beats:
  - T0, T1=U(T0), …, T_R with out_dir=0 and idx 0..R.
  - Then T_(R-1)=V(T_R), …, T0 with out_dir=1 and idx R-1..0.
  - out_last=1 only on the final backward beat (idx 0, dir 1).
- FSM states:
  - IDLE: in_ready=1. On in_valid: load T0 into out_tk and a shadow register; clear chk_err; out_valid=1 next cycle; go to FWD. Latency from load to first beat is 1 cycle.
  - FWD: on handshake (out_valid & out_ready):
    - if idx<R: out_tk<=U(out_tk), idx+1;
    - if idx==R: out_tk<=V(out_tk), idx=R-1, dir=1, go to BWD.
  - BWD: on handshake:
    - if idx>0: out_tk<=V(out_tk), idx-1; out_last asserts when the new idx is 0.
    - on the handshake of the last beat: compare out_tk with the shadow T0, set chk_err if they differ, drop out_valid, go to IDLE.
- Backpressure: while out_valid & !out_ready, all outputs hold stable. No bubbles: one update per handshake cycle, so throughput is 1 beat/cycle with out_ready held high.
- in_valid is ignored outside IDLE; a load is never queued.
- abort:
  - Has priority over a same-cycle handshake.
  - Next cycle: IDLE, out_valid=0, out_last=0; chk_err unchanged.
- rst asserted mid-sequence: immediate return to reset values; no partial beat is emitted.
- Index arithmetic is 4 bits and never wraps, since ROUNDS<=15.
- ROUNDS=1 gives 3 beats: T0, T1, T0.

Test Plan:
- Load in_tk=0x0000_0000_0000_0000, ROUNDS=7, out_ready=1 -> 15 consecutive beats, all out_tk=0; idx 0..7 then 6..0; out_last only on the 15th beat; chk_err=0.
- Load in_tk=0x0000_0000_0000_000F -> beat 0 out_tk=0x0000_0000_0000_000F; beat 1 out_tk=0x0007_0000_0000_0000 (idx 1, dir 0); final beat returns 0x0000_0000_0000_000F.
- Random in_tk, out_ready toggled pseudo-randomly -> stream matches a reference model of U/V beat-for-beat; outputs stable during every stall cycle; chk_err=0.
- Assert abort in FWD at idx 3, together with out_ready=1 -> no further beats; in_ready=1 the following cycle; a fresh load restarts at idx 0.
- Assert rst asynchronously mid-BWD -> out_valid=0 and out_tk=0 without waiting for a clock edge; in_valid during a running sequence is ignored, and the sequence completes unchanged.
- Force a bit flip on the internal round register during BWD (testbench force) -> chk_err=1 after the last beat and stays 1; the next load clears it.

Source files
------------

// File: rtl/qarma64_tweak_sched.sv
// Iterative QARMA-64 tweak schedule: streams T0..T_R forward, then walks back to T0
// with the inverse update, and flags any mismatch against the loaded tweak.
module qarma64_tweak_sched #(
  parameter int ROUNDS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_tk,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_tk,
  output logic [3:0]  out_idx,
  output logic        out_dir,
  output logic        out_last,
  output logic        chk_err
);

  typedef enum logic [1:0] {IDLE, FWD, BWD} state_e;

  localparam logic [3:0]  LAST_IDX    = 4'(ROUNDS);
  // Cell shuffle source table, cell 0 in the top nibble.
  localparam logic [63:0] H_MAP       = 64'h65EF_0123_7CD4_89AB;
  // Bit i set when cell i goes through the omega LFSR.
  localparam logic [15:0] OMEGA_CELLS = 16'h291B;

  function automatic logic [63:0] tk_fwd(input logic [63:0] x);
    logic [63:0] y;
    logic [3:0]  src;
    logic [3:0]  c;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      src = H_MAP[63-4*i -: 4];
      c   = x[63-4*int'(src) -: 4];
      if (OMEGA_CELLS[i]) c = {c[0] ^ c[1], c[3], c[2], c[1]};
      y[63-4*i -: 4] = c;
    end
    return y;
  endfunction

  function automatic logic [63:0] tk_bwd(input logic [63:0] x);
    logic [63:0] y;
    logic [3:0]  dst;
    logic [3:0]  c;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      c = x[63-4*i -: 4];
      if (OMEGA_CELLS[i]) c = {c[2], c[1], c[0], c[3] ^ c[0]};
      dst = H_MAP[63-4*i -: 4];
      y[63-4*int'(dst) -: 4] = c;
    end
    return y;
  endfunction

  state_e      state_q, state_d;
  logic [63:0] tk_q, tk_d;
  logic [63:0] shadow_q, shadow_d;
  logic [3:0]  idx_q, idx_d;
  logic        dir_q, dir_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        hs;

  assign hs = valid_q & out_ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    tk_d     = tk_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    valid_d  = valid_q;
    last_d   = last_q;
    err_d    = err_q;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          tk_d     = in_tk;
          shadow_d = in_tk;
          idx_d    = '0;
          dir_d    = 1'b0;
          last_d   = 1'b0;
          err_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = FWD;
        end
        FWD: if (hs) begin
          if (idx_q == LAST_IDX) begin
            tk_d    = tk_bwd(tk_q);
            idx_d   = LAST_IDX - 4'd1;
            dir_d   = 1'b1;
            last_d  = (LAST_IDX == 4'd1);
            state_d = BWD;
          end else begin
            tk_d  = tk_fwd(tk_q);
            idx_d = idx_q + 4'd1;
          end
        end
        BWD: if (hs) begin
          if (idx_q != 4'd0) begin
            tk_d   = tk_bwd(tk_q);
            idx_d  = idx_q - 4'd1;
            last_d = (idx_q == 4'd1);
          end else begin
            // Backward walk must land exactly on the loaded tweak.
            err_d   = err_q | (tk_q != shadow_q);
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tk_q     <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tk_q     <= tk_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = valid_q;
  assign out_tk    = tk_q;
  assign out_idx   = idx_q;
  assign out_dir   = dir_q;
  assign out_last  = last_q;
  assign chk_err   = err_q;

endmodule

// File: tb/tb_qarma64_tweak_sched.sv
// Self-checking bench for qarma64_tweak_sched: table vectors, randomized stalls against
// a cell-array reference model, plus abort, async reset and injected-fault sequences.
module tb_qarma64_tweak_sched;

  localparam int R    = 7;
  localparam int NB   = 2 * R + 1;
  localparam int MAXC = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_tk = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_tk;
  logic [3:0]  out_idx;
  logic        out_dir;
  logic        out_last;
  logic        chk_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qarma64_tweak_sched #(.ROUNDS(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tk    (in_tk),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tk   (out_tk),
    .out_idx  (out_idx),
    .out_dir  (out_dir),
    .out_last (out_last),
    .chk_err  (chk_err)
  );

  typedef struct {
    logic [63:0] tk;
    logic [63:0] beat1;
  } vec_t;

  typedef struct {
    logic [63:0] tk;
    logic [3:0]  idx;
    logic        dir;
    logic        last;
  } beat_t;

  vec_t  vecs[4];
  beat_t exp_q[$];
  int    h_tab[16]  = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
  int    om_tab[7]  = '{0, 1, 3, 4, 8, 11, 13};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_om(input int i);
    foreach (om_tab[j]) if (om_tab[j] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] u_ref(input logic [63:0] x);
    int c[16];
    int y[16];
    logic [63:0] r;
    for (int i = 0; i < 16; i++) c[i] = int'((x >> (60 - 4*i)) & 64'hF);
    for (int i = 0; i < 16; i++) y[i] = c[h_tab[i]];
    for (int i = 0; i < 16; i++)
      if (is_om(i)) y[i] = (y[i] >> 1) | (((y[i] ^ (y[i] >> 1)) & 1) << 3);
    r = '0;
    for (int i = 0; i < 16; i++) r |= 64'(y[i]) << (60 - 4*i);
    return r;
  endfunction

  function automatic logic [63:0] v_ref(input logic [63:0] x);
    int c[16];
    int y[16];
    logic [63:0] r;
    for (int i = 0; i < 16; i++) c[i] = int'((x >> (60 - 4*i)) & 64'hF);
    for (int i = 0; i < 16; i++)
      if (is_om(i)) c[i] = ((c[i] << 1) & 14) | (((c[i] >> 3) ^ c[i]) & 1);
    for (int i = 0; i < 16; i++) y[h_tab[i]] = c[i];
    r = '0;
    for (int i = 0; i < 16; i++) r |= 64'(y[i]) << (60 - 4*i);
    return r;
  endfunction

  task automatic build_expected(input logic [63:0] t0);
    logic [63:0] t;
    exp_q.delete();
    t = t0;
    for (int r = 0; r <= R; r++) begin
      exp_q.push_back('{tk: t, idx: 4'(r), dir: 1'b0, last: 1'b0});
      if (r < R) t = u_ref(t);
    end
    for (int j = 1; j <= R; j++) begin
      t = v_ref(t);
      exp_q.push_back('{tk: t, idx: 4'(R - j), dir: 1'b1, last: (j == R)});
    end
  endtask

  // Load t0 and consume the whole stream; stall_pct sets how often out_ready is low.
  task automatic run_seq(input logic [63:0] t0, input int stall_pct, input bit poke,
                         input logic [63:0] b1, input bit use_b1);
    int k;
    int cyc;
    bit stalled;
    logic [63:0] prev_tk;
    logic [5:0]  prev_ctl;
    build_expected(t0);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_tk     = t0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = poke;
    in_tk    = ~t0;
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    prev_tk = '0;
    prev_ctl = '0;
    while (k < NB && cyc < MAXC) begin
      check("out_valid", out_valid, 1);
      check("in_ready_busy", in_ready, 0);
      if (stalled) begin
        check("stable_tk", out_tk, prev_tk);
        check("stable_ctl", {out_idx, out_dir, out_last}, prev_ctl);
      end
      check("tk", out_tk, exp_q[k].tk);
      check("idx", out_idx, exp_q[k].idx);
      check("dir", out_dir, exp_q[k].dir);
      check("last", out_last, exp_q[k].last);
      check("chk_err_busy", chk_err, 0);
      if (use_b1 && k == 1) check("beat1_tk", out_tk, b1);
      if (k == NB - 1) check("final_is_t0", out_tk, t0);
      prev_tk   = out_tk;
      prev_ctl  = {out_idx, out_dir, out_last};
      out_ready = ($urandom_range(99) >= stall_pct);
      stalled   = !out_ready;
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("beats_in_budget", k, NB);
    check("valid_drop", out_valid, 0);
    check("last_drop", out_last, 0);
    check("in_ready_back", in_ready, 1);
    check("chk_err_end", chk_err, 0);
  endtask

  // Start a sequence with out_ready high and stop once the given beat is on the outputs.
  task automatic load_and_reach(input logic [63:0] t0, input logic [3:0] idx, input logic dir);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_tk     = t0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == idx && out_dir == dir) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_beat", {out_valid, out_dir, out_idx}, {1'b1, dir, idx});
  endtask

  initial begin
    logic [63:0] flip_v;
    int n;

    vecs[0] = '{tk: 64'h0000_0000_0000_0000, beat1: 64'h0000_0000_0000_0000};
    vecs[1] = '{tk: 64'h0000_0000_0000_000F, beat1: 64'h0007_0000_0000_0000};
    vecs[2] = '{tk: 64'hF000_0000_0000_0000, beat1: 64'h0000_7000_0000_0000};
    vecs[3] = '{tk: 64'h0000_0000_1000_0000, beat1: 64'h0000_0000_0000_1000};

    #3;
    check("rst_valid", out_valid, 0);
    check("rst_tk", out_tk, 0);
    check("rst_idx", out_idx, 0);
    check("rst_dir", out_dir, 0);
    check("rst_last", out_last, 0);
    check("rst_chk_err", chk_err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 4; i++) run_seq(vecs[i].tk, 0, 1'b0, vecs[i].beat1, 1'b1);

    for (int i = 0; i < 5; i++) run_seq({$urandom, $urandom}, 40, (i == 2), '0, 1'b0);

    // Abort together with a handshake at forward index 3.
    load_and_reach({$urandom, $urandom}, 4'd3, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_chk_err", chk_err, 0);
    @(negedge clk);
    check("abort_no_beats", out_valid, 0);
    out_ready = 1'b0;
    run_seq({$urandom, $urandom}, 30, 1'b0, '0, 1'b0);

    // Asynchronous reset in the backward half.
    load_and_reach({$urandom, $urandom}, 4'd4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_tk", out_tk, 0);
    check("arst_idx", out_idx, 0);
    check("arst_dir", out_dir, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_valid_after", out_valid, 0);
    run_seq({$urandom, $urandom}, 20, 1'b0, '0, 1'b0);

    // Corrupt the round register during the backward half.
    load_and_reach({$urandom, $urandom}, 4'(R - 2), 1'b1);
    out_ready = 1'b0;
    flip_v = out_tk ^ 64'h0000_0001_0000_0000;
    force dut.tk_q = flip_v;
    @(negedge clk);
    release dut.tk_q;
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_last) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("fault_reach_last", out_last, 1);
    @(negedge clk);
    out_ready = 1'b0;
    check("fault_chk_err", chk_err, 1);
    check("fault_valid_drop", out_valid, 0);
    repeat (3) @(negedge clk);
    check("fault_chk_err_sticky", chk_err, 1);
    run_seq({$urandom, $urandom}, 0, 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
